lab2_multicycle_ctrl: RTL and testbench

LAB2_MULTICYCLE_CTRL -- requirements
Module: Multicycle_Ctrl

---
 rtl/lab2_multicycle_ctrl_pkg.sv | 101 ++++++++++
 rtl/lab2_multicycle_ctrl_if.sv | 41 ++++
 rtl/lab2_multicycle_ctrl.sv | 177 +++++++++++++++++
 tb/tb_lab2_multicycle_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/lab2_multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// ALU operation codes, mux selects and the bundled control word.
package lab2_multicycle_ctrl_pkg;

    localparam int STATE_W = 4;

    // FSM state encoding
    localparam logic [3:0] ST_IF    = 4'd0;
    localparam logic [3:0] ST_ID    = 4'd1;
    localparam logic [3:0] ST_EX_R  = 4'd2;
    localparam logic [3:0] ST_EX_I  = 4'd3;
    localparam logic [3:0] ST_MADDR = 4'd4;
    localparam logic [3:0] ST_MRD   = 4'd5;
    localparam logic [3:0] ST_MWR   = 4'd6;
    localparam logic [3:0] ST_WB_R  = 4'd7;
    localparam logic [3:0] ST_WB_I  = 4'd8;
    localparam logic [3:0] ST_WB_M  = 4'd9;
    localparam logic [3:0] ST_BR    = 4'd10;
    localparam logic [3:0] ST_JMP   = 4'd11;
    localparam logic [3:0] ST_ERR   = 4'd12;

    // Supported opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALU operation codes
    localparam logic [2:0] ALU_R   = 3'b010;
    localparam logic [2:0] ALU_ADD = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b011;
    localparam logic [2:0] ALU_BEQ = 3'b001;
    localparam logic [2:0] ALU_LUI = 3'b100;
    localparam logic [2:0] ALU_ORI = 3'b111;
    localparam logic [2:0] ALU_BNE = 3'b101;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // ALU operand selects
    localparam logic       SRCA_PC      = 1'b0;
    localparam logic       SRCA_RS      = 1'b1;
    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // Control word produced by the decoder each cycle
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       is_ori;
        logic       is_bne;
        logic       instr_done;
    } ctrl_t;

    // State that follows ID for a given opcode; unknown opcodes trap to ERR
    function automatic logic [3:0] decode_op(input logic [5:0] op);
        logic [3:0] nxt;
        case (op)
            OP_RTYPE:                        nxt = ST_EX_R;
            OP_ADDI, OP_SLTI, OP_LUI, OP_ORI: nxt = ST_EX_I;
            OP_LW, OP_SW:                    nxt = ST_MADDR;
            OP_BEQ, OP_BNE:                  nxt = ST_BR;
            OP_J:                            nxt = ST_JMP;
            default:                         nxt = ST_ERR;
        endcase
        return nxt;
    endfunction

    // ALU operation for the immediate-arithmetic group
    function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
        logic [2:0] alu;
        case (op)
            OP_SLTI: alu = ALU_SLT;
            OP_LUI:  alu = ALU_LUI;
            OP_ORI:  alu = ALU_ORI;
            default: alu = ALU_ADD;
        endcase
        return alu;
    endfunction

endpackage

// File: rtl/lab2_multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle. The controller is the master: it
// consumes the opcode, ALU flag and memory ack and drives all strobes.
interface lab2_multicycle_ctrl_if;
    import lab2_multicycle_ctrl_pkg::*;

    logic [5:0]         instr_op_i;
    logic               zero_i;
    logic               mem_ack_i;

    logic               mem_req_o;
    logic               mem_we_o;
    logic               IorD_o;
    logic               IRWrite_o;
    logic               PCWrite_o;
    logic [1:0]         PCSrc_o;
    logic               RegWrite_o;
    logic               RegDst_o;
    logic               MemtoReg_o;
    logic               ALUSrcA_o;
    logic [1:0]         ALUSrcB_o;
    logic [2:0]         ALU_op_o;
    logic               isOri_o;
    logic               isBne_o;
    logic               instr_done_o;
    logic               illegal_o;
    logic [STATE_W-1:0] state_o;

    modport master (
        input  instr_op_i, zero_i, mem_ack_i,
        output mem_req_o, mem_we_o, IorD_o, IRWrite_o, PCWrite_o, PCSrc_o,
               RegWrite_o, RegDst_o, MemtoReg_o, ALUSrcA_o, ALUSrcB_o,
               ALU_op_o, isOri_o, isBne_o, instr_done_o, illegal_o, state_o
    );

    modport slave (
        output instr_op_i, zero_i, mem_ack_i,
        input  mem_req_o, mem_we_o, IorD_o, IRWrite_o, PCWrite_o, PCSrc_o,
               RegWrite_o, RegDst_o, MemtoReg_o, ALUSrcA_o, ALUSrcB_o,
               ALU_op_o, isOri_o, isBne_o, instr_done_o, illegal_o, state_o
    );
endinterface

// File: rtl/lab2_multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM. Strobes are decoded from the current
// state (and ack/zero where the handshake needs a same-cycle response), and
// all outputs are forced to zero while reset is held.
module lab2_multicycle_ctrl
    import lab2_multicycle_ctrl_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    lab2_multicycle_ctrl_if.master bus
);

    logic [3:0] state_r;
    logic [3:0] nxt_state_s;
    logic [5:0] op_r;
    logic       illegal_r;
    ctrl_t      ctrl_s;
    ctrl_t      gated_s;

    // State, latched opcode and sticky illegal flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= ST_IF;
            op_r      <= 6'd0;
            illegal_r <= 1'b0;
        end else begin
            state_r <= nxt_state_s;
            if (state_r == ST_ID) begin
                op_r <= bus.instr_op_i;
            end else begin
                op_r <= op_r;
            end
            if (nxt_state_s == ST_ERR) begin
                illegal_r <= 1'b1;
            end else begin
                illegal_r <= illegal_r;
            end
        end
    end

    // Next-state and control-word decode
    always_comb begin
        nxt_state_s = state_r;
        ctrl_s      = '0;
        case (state_r)
            ST_IF: begin
                ctrl_s.mem_req   = 1'b1;
                ctrl_s.alu_src_a = SRCA_PC;
                ctrl_s.alu_src_b = SRCB_FOUR;
                ctrl_s.alu_op    = ALU_ADD;
                if (bus.mem_ack_i) begin
                    ctrl_s.ir_write = 1'b1;
                    ctrl_s.pc_write = 1'b1;
                    ctrl_s.pc_src   = PCSRC_ALU;
                    nxt_state_s     = ST_ID;
                end else begin
                    nxt_state_s = ST_IF;
                end
            end
            ST_ID: begin
                // Branch target is precomputed into ALUOut here
                ctrl_s.alu_src_a = SRCA_PC;
                ctrl_s.alu_src_b = SRCB_IMM_SH2;
                ctrl_s.alu_op    = ALU_ADD;
                nxt_state_s      = decode_op(bus.instr_op_i);
            end
            ST_EX_R: begin
                ctrl_s.alu_src_a = SRCA_RS;
                ctrl_s.alu_src_b = SRCB_RT;
                ctrl_s.alu_op    = ALU_R;
                nxt_state_s      = ST_WB_R;
            end
            ST_EX_I: begin
                ctrl_s.alu_src_a = SRCA_RS;
                ctrl_s.alu_src_b = SRCB_IMM;
                ctrl_s.alu_op    = imm_alu_op(op_r);
                ctrl_s.is_ori    = (op_r == OP_ORI);
                nxt_state_s      = ST_WB_I;
            end
            ST_MADDR: begin
                ctrl_s.alu_src_a = SRCA_RS;
                ctrl_s.alu_src_b = SRCB_IMM;
                ctrl_s.alu_op    = ALU_ADD;
                if (op_r == OP_SW) begin
                    nxt_state_s = ST_MWR;
                end else begin
                    nxt_state_s = ST_MRD;
                end
            end
            ST_MRD: begin
                ctrl_s.mem_req = 1'b1;
                ctrl_s.iord    = 1'b1;
                if (bus.mem_ack_i) begin
                    nxt_state_s = ST_WB_M;
                end else begin
                    nxt_state_s = ST_MRD;
                end
            end
            ST_MWR: begin
                ctrl_s.mem_req = 1'b1;
                ctrl_s.mem_we  = 1'b1;
                ctrl_s.iord    = 1'b1;
                if (bus.mem_ack_i) begin
                    ctrl_s.instr_done = 1'b1;
                    nxt_state_s       = ST_IF;
                end else begin
                    nxt_state_s = ST_MWR;
                end
            end
            ST_WB_R: begin
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.reg_dst    = 1'b1;
                ctrl_s.instr_done = 1'b1;
                nxt_state_s       = ST_IF;
            end
            ST_WB_I: begin
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.instr_done = 1'b1;
                nxt_state_s       = ST_IF;
            end
            ST_WB_M: begin
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.mem_to_reg = 1'b1;
                ctrl_s.instr_done = 1'b1;
                nxt_state_s       = ST_IF;
            end
            ST_BR: begin
                ctrl_s.alu_src_a  = SRCA_RS;
                ctrl_s.alu_src_b  = SRCB_RT;
                ctrl_s.pc_src     = PCSRC_ALUOUT;
                ctrl_s.instr_done = 1'b1;
                if (op_r == OP_BNE) begin
                    ctrl_s.alu_op   = ALU_BNE;
                    ctrl_s.is_bne   = 1'b1;
                    ctrl_s.pc_write = ~bus.zero_i;
                end else begin
                    ctrl_s.alu_op   = ALU_BEQ;
                    ctrl_s.pc_write = bus.zero_i;
                end
                nxt_state_s = ST_IF;
            end
            ST_JMP: begin
                ctrl_s.pc_src     = PCSRC_JUMP;
                ctrl_s.pc_write   = 1'b1;
                ctrl_s.instr_done = 1'b1;
                nxt_state_s       = ST_IF;
            end
            ST_ERR: begin
                nxt_state_s = ST_ERR;
            end
            default: begin
                // Unused encodings are treated as a fault and trapped
                nxt_state_s = ST_ERR;
            end
        endcase
    end

    assign gated_s = rst_i ? '0 : ctrl_s;

    assign bus.mem_req_o    = gated_s.mem_req;
    assign bus.mem_we_o     = gated_s.mem_we;
    assign bus.IorD_o       = gated_s.iord;
    assign bus.IRWrite_o    = gated_s.ir_write;
    assign bus.PCWrite_o    = gated_s.pc_write;
    assign bus.PCSrc_o      = gated_s.pc_src;
    assign bus.RegWrite_o   = gated_s.reg_write;
    assign bus.RegDst_o     = gated_s.reg_dst;
    assign bus.MemtoReg_o   = gated_s.mem_to_reg;
    assign bus.ALUSrcA_o    = gated_s.alu_src_a;
    assign bus.ALUSrcB_o    = gated_s.alu_src_b;
    assign bus.ALU_op_o     = gated_s.alu_op;
    assign bus.isOri_o      = gated_s.is_ori;
    assign bus.isBne_o      = gated_s.is_bne;
    assign bus.instr_done_o = gated_s.instr_done;
    assign bus.illegal_o    = illegal_r & ~rst_i;
    assign bus.state_o      = rst_i ? ST_IF : state_r;

endmodule

// File: tb/tb_lab2_multicycle_ctrl.sv
// Directed bench for the multicycle controller. Each step pushes the expected
// full output vector into a scoreboard queue and pops it on the falling edge.
module tb_lab2_multicycle_ctrl;
    import lab2_multicycle_ctrl_pkg::*;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    lab2_multicycle_ctrl_if bus();

    lab2_multicycle_ctrl dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       tag;
        logic [23:0] v;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [23:0] obs_s;

    assign obs_s = {bus.mem_req_o, bus.mem_we_o, bus.IorD_o, bus.IRWrite_o,
                    bus.PCWrite_o, bus.PCSrc_o, bus.RegWrite_o, bus.RegDst_o,
                    bus.MemtoReg_o, bus.ALUSrcA_o, bus.ALUSrcB_o, bus.ALU_op_o,
                    bus.isOri_o, bus.isBne_o, bus.instr_done_o, bus.illegal_o,
                    bus.state_o};

    // Expected outputs for a state, written from the control table
    function automatic logic [23:0] spec_out(input logic [3:0] st, input logic [5:0] op,
                                             input logic z, input logic ack);
        logic req = 1'b0, we = 1'b0, iord = 1'b0, irw = 1'b0, pcw = 1'b0;
        logic rw = 1'b0, rd = 1'b0, m2r = 1'b0, sa = 1'b0, ori = 1'b0;
        logic bne = 1'b0, done = 1'b0, ill = 1'b0;
        logic [1:0] pcs = 2'b00, sb = 2'b00;
        logic [2:0] alu = 3'b000;
        case (st)
            ST_IF:    begin req = 1'b1; sb = 2'b01; alu = 3'b110; irw = ack; pcw = ack; end
            ST_ID:    begin sb = 2'b11; alu = 3'b110; end
            ST_EX_R:  begin sa = 1'b1; sb = 2'b00; alu = 3'b010; end
            ST_EX_I:  begin
                sa = 1'b1; sb = 2'b10;
                alu = (op == 6'b001010) ? 3'b011 : (op == 6'b001111) ? 3'b100 :
                      (op == 6'b001101) ? 3'b111 : 3'b110;
                ori = (op == 6'b001101);
            end
            ST_MADDR: begin sa = 1'b1; sb = 2'b10; alu = 3'b110; end
            ST_MRD:   begin req = 1'b1; iord = 1'b1; end
            ST_MWR:   begin req = 1'b1; iord = 1'b1; we = 1'b1; done = ack; end
            ST_WB_R:  begin rw = 1'b1; rd = 1'b1; done = 1'b1; end
            ST_WB_I:  begin rw = 1'b1; done = 1'b1; end
            ST_WB_M:  begin rw = 1'b1; m2r = 1'b1; done = 1'b1; end
            ST_BR:    begin
                sa = 1'b1; pcs = 2'b01; done = 1'b1;
                if (op == 6'b000101) begin alu = 3'b101; bne = 1'b1; pcw = ~z; end
                else begin alu = 3'b001; pcw = z; end
            end
            ST_JMP:   begin pcs = 2'b10; pcw = 1'b1; done = 1'b1; end
            ST_ERR:   begin ill = 1'b1; end
            default:  begin ill = 1'b0; end
        endcase
        return {req, we, iord, irw, pcw, pcs, rw, rd, m2r, sa, sb, alu, ori, bne, done, ill, st};
    endfunction

    // One clock cycle: drive, predict, compare mid-cycle, advance.
    // Opcode input is scrambled outside IF/ID to prove it is latched.
    task automatic step(input string tag, input logic r, input logic [3:0] st,
                        input logic [5:0] op, input logic z, input logic ack);
        exp_t e;
        rst_i          = r;
        bus.instr_op_i = (st == ST_IF || st == ST_ID) ? op : ~op;
        bus.zero_i     = z;
        bus.mem_ack_i  = ack;
        sb_q.push_back('{tag, r ? 24'h000000 : spec_out(st, op, z, ack)});
        @(negedge clk_i);
        e = sb_q.pop_front();
        n_cmp++;
        assert (obs_s === e.v) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs_s, e.v);
        end
        @(posedge clk_i);
        #1;
    endtask

    logic [5:0] i_ops [4];

    initial begin
        i_ops = '{6'b001000, 6'b001010, 6'b001111, 6'b001101};
        bus.instr_op_i = 6'd0;
        bus.zero_i     = 1'b0;
        bus.mem_ack_i  = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        step("reset_hold", 1'b1, ST_IF, 6'd0, 1'b0, 1'b1);

        // Immediate group with zero-wait fetch: IF, ID, EX_I, WB_I
        for (int k = 0; k < 4; k++) begin
            step("i_if",  1'b0, ST_IF,   i_ops[k], 1'b0, 1'b1);
            step("i_id",  1'b0, ST_ID,   i_ops[k], 1'b0, 1'b0);
            step("i_ex",  1'b0, ST_EX_I, i_ops[k], 1'b0, 1'b0);
            step("i_wb",  1'b0, ST_WB_I, i_ops[k], 1'b0, 1'b0);
        end

        // R-type
        step("r_if",  1'b0, ST_IF,   6'b000000, 1'b0, 1'b1);
        step("r_id",  1'b0, ST_ID,   6'b000000, 1'b0, 1'b0);
        step("r_ex",  1'b0, ST_EX_R, 6'b000000, 1'b0, 1'b0);
        step("r_wb",  1'b0, ST_WB_R, 6'b000000, 1'b0, 1'b0);

        // lw with one wait cycle in IF and MRD (done on cycle 7); stray ack in ID/MADDR
        step("lw_if0",  1'b0, ST_IF,    6'b100011, 1'b0, 1'b0);
        step("lw_if1",  1'b0, ST_IF,    6'b100011, 1'b0, 1'b1);
        step("lw_id",   1'b0, ST_ID,    6'b100011, 1'b0, 1'b1);
        step("lw_addr", 1'b0, ST_MADDR, 6'b100011, 1'b0, 1'b1);
        step("lw_rd0",  1'b0, ST_MRD,   6'b100011, 1'b0, 1'b0);
        step("lw_rd1",  1'b0, ST_MRD,   6'b100011, 1'b0, 1'b1);
        step("lw_wb",   1'b0, ST_WB_M,  6'b100011, 1'b0, 1'b0);

        // sw zero-wait
        step("sw_if",   1'b0, ST_IF,    6'b101011, 1'b0, 1'b1);
        step("sw_id",   1'b0, ST_ID,    6'b101011, 1'b0, 1'b0);
        step("sw_addr", 1'b0, ST_MADDR, 6'b101011, 1'b0, 1'b0);
        step("sw_wr",   1'b0, ST_MWR,   6'b101011, 1'b0, 1'b1);

        // Branches over both zero values, then jump
        for (int k = 0; k < 4; k++) begin
            logic [5:0] bop;
            logic       bz;
            bop = (k < 2) ? 6'b000100 : 6'b000101;
            bz  = (k % 2 == 0) ? 1'b1 : 1'b0;
            step("br_if", 1'b0, ST_IF, bop, bz, 1'b1);
            step("br_id", 1'b0, ST_ID, bop, bz, 1'b0);
            step("br_ex", 1'b0, ST_BR, bop, bz, 1'b0);
        end
        step("j_if",  1'b0, ST_IF,  6'b000010, 1'b0, 1'b1);
        step("j_id",  1'b0, ST_ID,  6'b000010, 1'b0, 1'b0);
        step("j_ex",  1'b0, ST_JMP, 6'b000010, 1'b0, 1'b0);

        // Reset during an unacknowledged store write
        step("swr_if",   1'b0, ST_IF,    6'b101011, 1'b0, 1'b1);
        step("swr_id",   1'b0, ST_ID,    6'b101011, 1'b0, 1'b0);
        step("swr_addr", 1'b0, ST_MADDR, 6'b101011, 1'b0, 1'b0);
        step("swr_wr",   1'b0, ST_MWR,   6'b101011, 1'b0, 1'b0);
        step("swr_rst",  1'b1, ST_MWR,   6'b101011, 1'b0, 1'b0);
        step("swr_after",1'b0, ST_IF,    6'b101011, 1'b0, 1'b0);
        step("swr_if2",  1'b0, ST_IF,    6'b101011, 1'b0, 1'b1);
        step("swr_id2",  1'b0, ST_ID,    6'b101011, 1'b0, 1'b0);

        // Wait: the previous ID decoded sw, finish it cleanly
        step("swr_addr2",1'b0, ST_MADDR, 6'b101011, 1'b0, 1'b0);
        step("swr_wr2",  1'b0, ST_MWR,   6'b101011, 1'b0, 1'b1);

        // Illegal opcode: trap, stay sticky with stray acks, cleared by reset
        step("ill_if", 1'b0, ST_IF, 6'b111111, 1'b0, 1'b1);
        step("ill_id", 1'b0, ST_ID, 6'b111111, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            step("ill_err", 1'b0, ST_ERR, 6'b111111, k[1], k[0]);
        end
        step("ill_rst",   1'b1, ST_ERR, 6'b111111, 1'b0, 1'b0);
        step("ill_after", 1'b0, ST_IF,  6'b001000, 1'b0, 1'b1);
        step("ill_id2",   1'b0, ST_ID,  6'b001000, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
